sha256_block_core: RTL and testbench
====================================

Name: sha256_block_core

Overview:
- Iterative SHA-256 compression engine. Processes one pre-padded 512-bit message block per start pulse, one round per clock.
- Keeps its own chaining value H0..H7 across successive blocks, so a message is hashed by feeding its padded blocks in order.
- Sits under the SHA-256 stream/padding controller, which owns word assembly, padding and length encoding.

Parameters:
- None. All SHA-256 constants are fixed and come from the shared package.

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  single-cycle request; sampled only in IDLE
- block_in  in  512  message block, big-endian; W0 = block_in[511:480] … W15 = block_in[31:0]
- hash_out  out  256  updated chaining value; H0 in [255:224] … H7 in [31:0]
- ready  out  1  one-cycle pulse marking hash_out newly valid

Behaviour:
- Reset is asynchronous, active-high; clock is clk.
- Reset values: ready=0, hash_out=0, FSM=IDLE, round counter=0, working regs a..h=0.
- Reset loads the chaining registers with the standard IV: 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19.
- The IV is restored only by rst. Starting a new message requires asserting rst first.
- FSM states: IDLE, ROUND, DONE.
- IDLE, start=1 at edge E0:
  - capture block_in into a 16-word schedule window;
  - a..h <= H0..H7; t <= 0; go to ROUND.
- ROUND, edges E1..E64: one round per edge, t = 0..63.
  - For t<16, Wt comes from the captured window.
  - Otherwise Wt = σ1(Wt-2) + Wt-7 + σ0(Wt-15) + Wt-16, computed with a window shift.
  - T1 = h + Σ1(e) + Ch(e,f,g) + Kt + Wt; T2 = Σ0(a) + Maj(a,b,c).
  - Then h=g, g=f, f=e, e=d+T1, d=c, c=b, b=a, a=T1+T2.
  - All additions are modulo 2^32.
  - After t=63, go to DONE.
- DONE, edge E65:
  - Hi <= Hi + {a..h}i and hash_out <= the same sums;
  - ready <= 1; go to IDLE.
- ready falls at E66. Latency is 65 clocks from the start-sampling edge to ready high; ready is high for exactly one cycle.
- Back-to-back use: a start in IDLE at E66 is accepted normally.
- hash_out holds its value until the next DONE or reset.
- start while in ROUND or DONE is ignored and not queued.
- start held high for several cycles in IDLE starts exactly one block per IDLE visit.
- block_in is sampled only at the accepting edge; later changes have no effect.
- rst asserted mid-block:
  - abort immediately, clear ready and hash_out, reload the IV;
  - the partial block is discarded.

Optional Feature:
- Macro SHA256_BLOCK_CORE_TRACE_EN.
- Defined: simulation-only $display at DONE showing the block count since reset and the new hash_out in hex.
- Undefined: no display statements are compiled.
- Synthesized logic is identical in both cases.

Decomposition:
- Package sha256_pkg holds:
  - K[0:63] round constants and the 256-bit IV constant;
  - the FSM state enum;
  - functions Ch, Maj, Σ0, Σ1, σ0, σ1 (32-bit).
- One sub-module, sha256_msg_schedule:
  - 16×32 shift window;
  - load on accept, shift per round;
  - outputs the current Wt.

Test Plan:
- "abc" block (61626380, 14 zero words, 00000018) after reset -> ready pulses 65 clocks after the start edge, one cycle wide; hash_out = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Empty-message block (80000000, then zeros) after reset -> hash_out = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq":
  - block 1 -> 85e655d6 417a1795 3363376a 624cde5c 76e09589 cac5f811 cc4b32c1 f20e533a;
  - block 2 -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- start pulsed during ROUND and block_in changed after acceptance -> single ready pulse; "abc" result unchanged.
- rst asserted at round 30, then "abc" block -> ready=0 and hash_out=0 during reset; afterwards the correct "abc" digest.
- Reset values and hold: after rst, ready=0 and hash_out=0; after a completed block, hash_out stable over 100 idle cycles.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, FSM state type and the 32-bit round/schedule
// helper functions used by the compression core and its message schedule.
package sha256_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_msg_schedule.sv
// 16-word sliding message-schedule window: loads a block on accept and shifts
// once per round, always presenting the current Wt at the head.
module sha256_msg_schedule
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         load,
  input  logic         shift,
  input  logic [511:0] block_in,
  output logic [31:0]  wt
);

  logic [31:0] win [0:15];
  logic [31:0] w_new;

  // win[k] holds W(t+k); the incoming word is W(t+16).
  assign w_new = small_sigma1(win[14]) + win[9] + small_sigma0(win[1]) + win[0];
  assign wt    = win[0];

  always_ff @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 16; i++) win[i] <= block_in[511 - 32*i -: 32];
    end else if (shift) begin
      for (int i = 0; i < 15; i++) win[i] <= win[i + 1];
      win[15] <= w_new;
    end
  end

endmodule

// File: rtl/sha256_block_core.sv
// Iterative SHA-256 compression core, one round per clock, chaining value kept
// across blocks. Define SHA256_BLOCK_CORE_TRACE_EN for a simulation trace at DONE.
module sha256_block_core
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [511:0] block_in,
  output logic [255:0] hash_out,
  output logic         ready
);

  state_t       state;
  logic [5:0]   t;
  logic [31:0]  a, b, c, d, e, f, g, h;
  logic [255:0] h_chain;
  logic [255:0] hash_next;
  logic [255:0] work;
  logic [31:0]  wt, t1, t2;
  logic         sched_load, sched_shift;

  assign sched_load  = (state == IDLE) && start;
  assign sched_shift = (state == ROUND);

  sha256_msg_schedule u_sched (
    .clk      (clk),
    .load     (sched_load),
    .shift    (sched_shift),
    .block_in (block_in),
    .wt       (wt)
  );

  assign t1   = h + big_sigma1(e) + ch(e, f, g) + K[t] + wt;
  assign t2   = big_sigma0(a) + maj(a, b, c);
  assign work = {a, b, c, d, e, f, g, h};

  // Per-word modular sums; carries must not ripple between chaining words.
  always_comb begin
    hash_next = '0;
    for (int i = 0; i < 8; i++)
      hash_next[32*i +: 32] = h_chain[32*i +: 32] + work[32*i +: 32];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      t        <= '0;
      {a, b, c, d, e, f, g, h} <= '0;
      h_chain  <= IV;
      hash_out <= '0;
      ready    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready <= 1'b0;
          if (start) begin
            {a, b, c, d, e, f, g, h} <= h_chain;
            t     <= '0;
            state <= ROUND;
          end
        end
        ROUND: begin
          h <= g;
          g <= f;
          f <= e;
          e <= d + t1;
          d <= c;
          c <= b;
          b <= a;
          a <= t1 + t2;
          t <= t + 6'd1;
          if (t == 6'd63) state <= DONE;
        end
        DONE: begin
          h_chain  <= hash_next;
          hash_out <= hash_next;
          ready    <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SHA256_BLOCK_CORE_TRACE_EN
  int unsigned trace_blocks;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trace_blocks <= 0;
    end else if (state == DONE) begin
      trace_blocks <= trace_blocks + 1;
      $display("sha256_block_core: block %0d hash %h", trace_blocks + 1, hash_next);
    end
  end
`endif

endmodule

// File: tb/tb_sha256_block_core.sv
// Self-checking bench for sha256_block_core: known-answer vectors, protocol
// corner cases and random chained blocks against an array-based SHA-256 model.
module tb_sha256_block_core;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [511:0] block_in = '0;
  logic [255:0] hash_out;
  logic         ready;

  int checks = 0;
  int errors = 0;

  localparam logic [255:0] IV_REF = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  sha256_block_core dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .block_in (block_in),
    .hash_out (hash_out),
    .ready    (ready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook SHA-256 compression over a fully expanded 64-word schedule.
  function automatic logic [255:0] ref_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] s0, s1, t1, t2;
    logic [255:0] res;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = m_rotr(w[i-15], 7) ^ m_rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = m_rotr(w[i-2], 17) ^ m_rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
    for (int i = 0; i < 64; i++) begin
      t1 = v[7] + (m_rotr(v[4], 6) ^ m_rotr(v[4], 11) ^ m_rotr(v[4], 25))
           + ((v[4] & v[5]) ^ (~v[4] & v[6])) + sha256_pkg::K[i] + w[i];
      t2 = (m_rotr(v[0], 2) ^ m_rotr(v[0], 13) ^ m_rotr(v[0], 22))
           + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
    return res;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs one block; with disturb set, pokes start during ROUND/DONE and
  // scrambles block_in after acceptance.
  task automatic run_block(input string tag, input logic [511:0] blk, input bit disturb,
                           output logic [255:0] hres);
    int  lat;
    int  extra;
    bit  seen;
    @(negedge clk);
    block_in = blk;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    if (disturb) block_in = {16{$urandom()}};
    lat  = 0;
    seen = 1'b0;
    for (int k = 1; k <= 200 && !seen; k++) begin
      start = disturb && (k == 10 || k == 40 || k == 64 || k == 65);
      @(posedge clk);
      @(negedge clk);
      if (ready) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    start = 1'b0;
    check_eq({tag, "_latency"}, 256'(lat), 256'd65);
    hres = hash_out;
    @(posedge clk);
    @(negedge clk);
    check_eq({tag, "_ready_width"}, 256'(ready), 256'd0);
    if (disturb) begin
      extra = 0;
      for (int k = 0; k < 70; k++) begin
        @(posedge clk);
        @(negedge clk);
        if (ready) extra++;
      end
      check_eq({tag, "_extra_pulses"}, 256'(extra), 256'd0);
    end
  endtask

  logic [511:0] abc_blk, empty_blk, two_b1, two_b2, rblk;
  logic [255:0] res, model_h, hcap;
  int           first_rdy, second_rdy, pulses;
  bit           stable;

  initial begin
    abc_blk   = {32'h61626380, 448'h0, 32'h00000018};
    empty_blk = {32'h80000000, 480'h0};
    two_b1    = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    two_b2    = {480'h0, 32'h000001c0};

    repeat (2) @(negedge clk);
    check_eq("reset_ready", 256'(ready), 256'd0);
    check_eq("reset_hash", hash_out, 256'd0);
    rst = 1'b0;

    run_block("abc", abc_blk, 1'b0, res);
    check_eq("abc_digest", res,
      256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad);

    do_reset();
    run_block("empty", empty_blk, 1'b0, res);
    check_eq("empty_digest", res,
      256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855);

    do_reset();
    run_block("two_b1", two_b1, 1'b0, res);
    check_eq("two_b1_digest", res,
      256'h85e655d6_417a1795_3363376a_624cde5c_76e09589_cac5f811_cc4b32c1_f20e533a);
    run_block("two_b2", two_b2, 1'b0, res);
    check_eq("two_b2_digest", res,
      256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1);

    do_reset();
    run_block("abc_disturb", abc_blk, 1'b1, res);
    check_eq("abc_disturb_digest", res,
      256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad);

    // Abort around round 30, then the same core must produce a clean "abc".
    @(negedge clk);
    block_in = abc_blk;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("midrst_ready", 256'(ready), 256'd0);
    check_eq("midrst_hash", hash_out, 256'd0);
    @(negedge clk);
    rst = 1'b0;
    run_block("abc_after_rst", abc_blk, 1'b0, res);
    check_eq("abc_after_rst_digest", res,
      256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad);

    // Random blocks chained from the IV, some with disturbance.
    do_reset();
    model_h = IV_REF;
    for (int n = 0; n < 4; n++) begin
      for (int w = 0; w < 16; w++) rblk[32*w +: 32] = $urandom();
      run_block("rand", rblk, n[0], res);
      model_h = ref_compress(model_h, rblk);
      check_eq("rand_digest", res, model_h);
    end

    // start held high: exactly one block per IDLE visit, back-to-back at E66.
    do_reset();
    for (int w = 0; w < 16; w++) rblk[32*w +: 32] = $urandom();
    @(negedge clk);
    block_in = rblk;
    start    = 1'b1;
    first_rdy  = 0;
    second_rdy = 0;
    pulses     = 0;
    for (int k = 0; k <= 140; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 66) start = 1'b0;
      if (ready) begin
        pulses++;
        if (first_rdy == 0) first_rdy = k;
        else second_rdy = k;
      end
    end
    check_eq("b2b_pulses", 256'(pulses), 256'd2);
    check_eq("b2b_first", 256'(first_rdy), 256'd65);
    check_eq("b2b_second", 256'(second_rdy), 256'd131);
    check_eq("b2b_digest", hash_out, ref_compress(ref_compress(IV_REF, rblk), rblk));

    hcap   = hash_out;
    stable = 1'b1;
    for (int k = 0; k < 100; k++) begin
      block_in = {16{$urandom()}};
      @(posedge clk);
      @(negedge clk);
      if (hash_out !== hcap || ready !== 1'b0) stable = 1'b0;
    end
    check_eq("idle_hold", 256'(stable), 256'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
